// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : RV32I execute-stage wrapper around the 32-bit ALU. Adds signed
//            compares, SRA sign fill and branch targets, and registers the
//            outcome into a valid/ready stage with a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic [2:0]      alu_compare,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_sll  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_slt  = 4'd8;
    localparam logic [3:0] c_op_sltu = 4'd9;
    localparam logic [3:0] c_op_beq  = 4'd10;
    localparam logic [3:0] c_op_bne  = 4'd11;
    localparam logic [3:0] c_op_blt  = 4'd12;
    localparam logic [3:0] c_op_bge  = 4'd13;
    localparam logic [3:0] c_op_bltu = 4'd14;
    localparam logic [3:0] c_op_bgeu = 4'd15;

    localparam logic [2:0] c_alu_sub = 3'b001;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            wen;
        logic            taken;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t          w_entry;
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;

    logic            w_slt;
    logic            w_ltu;
    logic            w_eq;
    logic [XLEN-1:0] w_sign_fill;
    logic            w_accept;
    logic            w_main_free;
    logic            w_unused;

    // ------------------------------------------------------------------
    // ALU drive: compare-class ops (8-15) run the ALU as a subtractor and
    // only its compare flags are consumed.
    // ------------------------------------------------------------------
    assign alu_a    = in_a;
    assign alu_b    = in_b;
    assign alu_ctrl = in_op[3] ? c_alu_sub : in_op[2:0];

    assign w_ltu    = alu_compare[2];
    assign w_eq     = alu_compare[1];
    assign w_slt    = (in_a[XLEN-1] != in_b[XLEN-1]) ? in_a[XLEN-1] : alu_compare[2];
    assign w_unused = alu_compare[0];

    // The ALU shifts logically; ones are OR'd into the vacated high bits.
    assign w_sign_fill = ~({XLEN{1'b1}} >> in_b[4:0]);

    always_comb begin
        w_entry        = '0;
        w_entry.target = in_pc + in_imm;
        w_entry.rd     = in_rd;
        w_entry.wen    = (in_rd != 5'd0);
        w_entry.result = alu_result;
        w_entry.taken  = 1'b0;
        case (in_op)
            c_op_add, c_op_sub, c_op_and, c_op_or,
            c_op_xor, c_op_sll, c_op_srl: begin
                w_entry.result = alu_result;
            end
            c_op_sra: begin
                w_entry.result = in_a[XLEN-1] ? (alu_result | w_sign_fill) : alu_result;
            end
            c_op_slt: begin
                w_entry.result = {{(XLEN-1){1'b0}}, w_slt};
            end
            c_op_sltu: begin
                w_entry.result = {{(XLEN-1){1'b0}}, w_ltu};
            end
            c_op_beq, c_op_bne, c_op_blt,
            c_op_bge, c_op_bltu, c_op_bgeu: begin
                w_entry.result = '0;
                w_entry.rd     = 5'd0;
                w_entry.wen    = 1'b0;
                case (in_op)
                    c_op_beq:  w_entry.taken = w_eq;
                    c_op_bne:  w_entry.taken = ~w_eq;
                    c_op_blt:  w_entry.taken = w_slt;
                    c_op_bge:  w_entry.taken = ~w_slt;
                    c_op_bltu: w_entry.taken = w_ltu;
                    default:   w_entry.taken = ~w_ltu;
                endcase
            end
            default: begin
                w_entry.result = alu_result;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage with skid register. in_ready depends only on the
    // registered skid occupancy, so it never combinationally follows
    // out_ready.
    // ------------------------------------------------------------------
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & in_ready;
    assign w_main_free = ~r_main_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (w_main_free) begin
            // Skid can only be full while in_ready is low, so no accept
            // competes with the skid-to-main move.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid  = r_main_valid;
    assign out_result = r_main.result;
    assign out_rd     = r_main.rd;
    assign out_wen    = r_main.wen;
    assign out_taken  = r_main.taken;
    assign out_target = r_main.target;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Directed self-checking bench for ex_stage with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [2:0]  alu_compare;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_taken;
    logic [31:0] out_target;

    int errors = 0;
    int checks = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_pc       (in_pc),
        .in_imm      (in_imm),
        .in_rd       (in_rd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_compare (alu_compare),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_taken   (out_taken),
        .out_target  (out_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: logical shifts only, compare = {ltu, eq, gtu}.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            3'd5:    alu_result = alu_a << alu_b[4:0];
            default: alu_result = alu_a >> alu_b[4:0];
        endcase
        alu_compare = {alu_a < alu_b, alu_a == alu_b, alu_a > alu_b};
    end

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_pc  = pc;
        in_imm = imm;
        in_rd  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        set_in(4'd0, 32'd3, 32'd4, 32'd0, 32'd0, 5'd2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd7) begin errors++;
            $display("FAIL pre_reset_entry: valid=%0b result=%h want 1/00000007", out_valid, out_result); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %0b want 1", in_ready); end
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL async_reset_result: got %h want 0", out_result); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_alu_ops();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_in(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5);
        step();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_wen !== 1'b1 || out_rd !== 5'd5) begin errors++;
            $display("FAIL add_wrap: v=%0b res=%h wen=%0b rd=%0d want 1/00000000/1/5", out_valid, out_result, out_wen, out_rd); end
        set_in(4'd7, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd6);
        step();
        checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want f8000000", out_result); end
        set_in(4'd6, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd6);
        step();
        checks++; if (out_result !== 32'h0800_0000) begin errors++; $display("FAIL srl: got %h want 08000000", out_result); end
        set_in(4'd7, 32'h7000_0000, 32'd4, 32'd0, 32'd0, 5'd6);
        step();
        checks++; if (out_result !== 32'h0700_0000) begin errors++; $display("FAIL sra_pos: got %h want 07000000", out_result); end
        set_in(4'd0, 32'd2, 32'd3, 32'd0, 32'd0, 5'd0);
        step();
        checks++; if (out_result !== 32'd5 || out_wen !== 1'b0) begin errors++;
            $display("FAIL rd0_write: res=%h wen=%0b want 00000005/0", out_result, out_wen); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_compares();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_in(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        step();
        checks++; if (out_result !== 32'd1 || out_wen !== 1'b1) begin errors++;
            $display("FAIL slt: res=%h wen=%0b want 00000001/1", out_result, out_wen); end
        set_in(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        step();
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL sltu: got %h want 0", out_result); end
        set_in(4'd12, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        step();
        checks++; if (out_taken !== 1'b1 || out_rd !== 5'd0 || out_wen !== 1'b0) begin errors++;
            $display("FAIL blt: taken=%0b rd=%0d wen=%0b want 1/0/0", out_taken, out_rd, out_wen); end
        set_in(4'd15, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        step();
        checks++; if (out_taken !== 1'b1) begin errors++; $display("FAIL bgeu: got %0b want 1", out_taken); end
        set_in(4'd13, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        step();
        checks++; if (out_taken !== 1'b0) begin errors++; $display("FAIL bge: got %0b want 0", out_taken); end
        set_in(4'd10, 32'd5, 32'd5, 32'h100, 32'hFFFF_FFF0, 5'd9);
        step();
        checks++; if (out_taken !== 1'b1 || out_wen !== 1'b0 || out_result !== 32'd0 || out_target !== 32'h0000_00F0) begin errors++;
            $display("FAIL beq_target: taken=%0b wen=%0b res=%h tgt=%h want 1/0/0/000000f0",
                     out_taken, out_wen, out_result, out_target); end
        set_in(4'd11, 32'd5, 32'd5, 32'h100, 32'h8, 5'd9);
        step();
        checks++; if (out_taken !== 1'b0 || out_target !== 32'h108) begin errors++;
            $display("FAIL bne: taken=%0b tgt=%h want 0/00000108", out_taken, out_target); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);       // A = 2
        step();
        set_in(4'd3, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd2);     // B = ff
        step();
        checks++; if (in_ready !== 1'b0 || out_result !== 32'd2 || out_rd !== 5'd1) begin errors++;
            $display("FAIL skid_full: ready=%0b res=%h rd=%0d want 0/00000002/1", in_ready, out_result, out_rd); end
        set_in(4'd1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd3);      // C = 7, held until accepted
        step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd2) begin errors++;
            $display("FAIL hold_a: ready=%0b v=%0b res=%h want 0/1/00000002", in_ready, out_valid, out_result); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'hFF || out_rd !== 5'd2 || in_ready !== 1'b1) begin errors++;
            $display("FAIL emerge_b: v=%0b res=%h rd=%0d ready=%0b want 1/000000ff/2/1", out_valid, out_result, out_rd, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_result !== 32'd7 || out_rd !== 5'd3) begin errors++;
            $display("FAIL emerge_c: v=%0b res=%h rd=%0d want 1/00000007/3", out_valid, out_result, out_rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_dup: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(4'd0, 32'd10, 32'd1, 32'd0, 32'd0, 5'd4);
        step();
        set_in(4'd0, 32'd20, 32'd1, 32'd0, 32'd0, 5'd4);
        step();
        set_in(4'd0, 32'd30, 32'd1, 32'd0, 32'd0, 5'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL flush_full: v=%0b ready=%0b want 0/1", out_valid, in_ready); end
        // Flush with only main occupied: the concurrent handshake must be dropped.
        in_valid = 1'b1;
        set_in(4'd0, 32'd40, 32'd1, 32'd0, 32'd0, 5'd4);
        step();
        set_in(4'd0, 32'd50, 32'd1, 32'd0, 32'd0, 5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL flush_drop: v=%0b ready=%0b want 0/1", out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: v=%0b res=%h want 0", out_valid, out_result); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_in(4'd2, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd4);
        step();
        checks++; if (out_result !== 32'hF000) begin errors++; $display("FAIL b2b_and: got %h want 0000f000", out_result); end
        set_in(4'd4, 32'hFF, 32'h0F, 32'd0, 32'd0, 5'd4);
        step();
        checks++; if (out_result !== 32'hF0) begin errors++; $display("FAIL b2b_xor: got %h want 000000f0", out_result); end
        set_in(4'd5, 32'd1, 32'd31, 32'd0, 32'd0, 5'd4);
        step();
        checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL b2b_sll: got %h want 80000000", out_result); end
        set_in(4'd1, 32'd0, 32'd1, 32'd0, 32'd0, 5'd4);
        step();
        in_valid = 1'b0;
        checks++; if (out_result !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_sub_wrap: v=%0b res=%h want 1/ffffffff", out_valid, out_result); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b want 0", out_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_in(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        test_reset();
        test_alu_ops();
        test_compares();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute-stage wrapper for the RV32I core. It sits directly upstream of the 32-bit ALU: it drives the ALU's operands and 3-bit control, then consumes the ALU's Result and 3-bit compare ({A<B unsigned, A==B, A>B unsigned}).
- It adds what the ALU lacks: signed SLT/branch compares, arithmetic-shift sign fill, and branch target generation.
- It registers the outcome into a valid/ready output stage with a 2-entry skid buffer toward memory/writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_op  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
- in_a  in  32  operand A (rs1 or PC)
- in_b  in  32  operand B (rs2 or immediate)
- in_pc  in  32  instruction PC
- in_imm  in  32  branch offset, sign-extended
- in_rd  in  5  destination register
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_ctrl  out  3  to ALU control
- alu_result  in  32  from ALU Result
- alu_compare  in  3  from ALU compare
- out_valid  out  1  result entry valid
- out_ready  in  1  downstream accepts
- out_result  out  32  writeback value
- out_rd  out  5  destination; 0 for branches
- out_wen  out  1  register write enable
- out_taken  out  1  branch taken
- out_target  out  32  in_pc + in_imm (mod 2^32)

Behaviour:
- Reset (rst_n low, async): out_valid=0, in_ready=1, all out_* data=0, skid entries empty. Takes effect immediately, including mid-transfer; any in-flight entry is lost.
- ALU drive (combinational from inputs):
  - alu_a=in_a, alu_b=in_b.
  - alu_ctrl = op[2:0] for ops 0-7.
  - alu_ctrl = 001 (SUB) for ops 8-15; only compare is used for these.
- Signed less-than: slt = in_a[31] if in_a[31]!=in_b[31], else alu_compare[2].
- Unsigned less-than: ltu = alu_compare[2]. Equality: eq = alu_compare[1].
- SRA: result = alu_result | ~(32'hFFFFFFFF >> in_b[4:0]) when in_a[31]=1, else alu_result. Shift amount is always in_b[4:0].
- SLT/SLTU: result = {31'b0, slt} or {31'b0, ltu}.
- Branches:
  - taken: BEQ eq; BNE !eq; BLT slt; BGE !slt; BLTU ltu; BGEU !ltu.
  - Branches set wen=0, rd=0, result=0.
  - Non-branches set taken=0, wen=(in_rd!=0).
- Handshake:
  - Upstream transfer occurs when in_valid & in_ready. Downstream transfer occurs when out_valid & out_ready.
  - Latency: an entry accepted at edge N is visible on out_* after edge N.
  - Throughput: 1 entry/cycle while out_ready=1.
- Buffer:
  - Main output register plus one skid register.
  - in_ready is registered: in_ready = !skid_full.
  - Accept while the main register is occupied and not draining → the entry goes to the skid register and in_ready drops next cycle.
  - Main drains → skid moves to main the same edge; skid empties and in_ready returns to 1.
- out_* fields stay stable while out_valid & !out_ready; verification asserts this.
- Simultaneous accept and drain with an empty skid register: the new entry loads main directly; no bubble.
- flush: on that edge both entries are cleared, out_valid=0, in_ready=1. An input handshaking on the same edge is dropped. flush has priority over all loads.
- Overflow: never occurs, since in_ready=0 whenever the skid register is full.
- Wrap-around: out_target and ADD/SUB wrap modulo 2^32 with no flag.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid drops to 0 immediately, in_ready=1, out_result=0.
- ALU ops:
  - ADD 0xFFFFFFFF+1 → out_result=0, wen=1.
  - SRA in_a=0x80000000, in_b=4 → 0xF8000000.
  - SRL same operands → 0x08000000.
- Signed vs unsigned compares, in_a=0xFFFFFFFF, in_b=1:
  - SLT → 1, SLTU → 0.
  - BLT → taken=1, BGEU → taken=1.
  - BEQ with in_a=in_b=5 → taken=1, wen=0.
  - Branch target: pc=0x100, imm=0xFFFFFFF0 → out_target=0xF0.
- Backpressure:
  - Stream ops A, B, C with out_ready=0 → A held on out_*, B in skid, in_ready=0; C is not accepted.
  - Raise out_ready → A, B, C emerge in order on consecutive cycles with no loss or duplication.
- Flush: with both entries full, flush=1 concurrently with in_valid=1 → out_valid=0, in_ready=1 next cycle; the concurrent entry never appears.
- rd=0 write: ADD with in_rd=0 → out_wen=0; result still presented.
